sum_feeder: RTL and testbench

SUM_FEEDER -- requirements
Module: sum_feeder

---
 rtl/sum_feeder_pkg.sv | 19 +
 rtl/sample_buf.sv | 25 ++
 rtl/sum_feeder.sv | 163 ++++++++++++++++
 tb/tb_sum_feeder.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sum_feeder_pkg.sv
// Shared types and constants for the sum_feeder sample sequencer and its buffer.
package sum_feeder_pkg;

  localparam int DEPTH_DEF   = 16;
  localparam int TIMEOUT_DEF = 255;
  localparam int SAMPLE_W    = 8;
  localparam int SUM_W       = 16;
  localparam int CNT_W       = 8;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    START,
    STREAM,
    WAIT,
    REPORT
  } state_e;

endpackage

// File: rtl/sample_buf.sv
// Sample storage: synchronous write at a caller-supplied pointer, combinational read.
module sample_buf
  import sum_feeder_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF,
  parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                clk_i,
  input  logic                we_i,
  input  logic [AW-1:0]       waddr_i,
  input  logic [SAMPLE_W-1:0] wdata_i,
  input  logic [AW-1:0]       raddr_i,
  output logic [SAMPLE_W-1:0] rdata_o
);

  logic [SAMPLE_W-1:0] mem_q [DEPTH];

  // NOTE: storage has no reset; entries are only read below the sample count, so stale data is never observed.
  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/sum_feeder.sv
// Buffers samples, then replays them into an external accumulator and captures its sum.
module sum_feeder
  import sum_feeder_pkg::*;
#(
  parameter int DEPTH   = DEPTH_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                wr_en_i,
  input  logic [SAMPLE_W-1:0] wr_data_i,
  input  logic                flush_i,
  input  logic                go_i,
  output logic                busy_o,
  output logic [4:0]          count_o,
  output logic                acc_rst_no,
  output logic                start_o,
  output logic [7:0]          n_o,
  output logic [SAMPLE_W-1:0] data_o,
  input  logic                done_i,
  input  logic [SUM_W-1:0]    sum_i,
  output logic [SUM_W-1:0]    result_o,
  output logic                valid_o,
  output logic                err_o,
  output logic                ovf_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(DEPTH);
  localparam logic [TW-1:0]    TMO_LAST = TW'(TIMEOUT - 1);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [CNT_W-1:0]   n_q, n_d;
  logic [CNT_W-1:0]   idx_q, idx_d;
  logic [TW-1:0]      tmo_q, tmo_d;
  logic [SUM_W-1:0]   result_q, result_d;
  logic               err_q, err_d;
  logic               ovf_q, ovf_d;
  logic               acc_rst_n_q, acc_rst_n_d;
  logic               buf_we;
  logic [SAMPLE_W-1:0] buf_rdata;

  sample_buf #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_buf (
    .clk_i   (clk_i),
    .we_i    (buf_we),
    .waddr_i (count_q[AW-1:0]),
    .wdata_i (wr_data_i),
    .raddr_i (idx_q[AW-1:0]),
    .rdata_o (buf_rdata)
  );

  // NOTE: every signal gets its hold value first so no path through the case leaves one unassigned (no latches).
  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    n_d      = n_q;
    idx_d    = idx_q;
    tmo_d    = tmo_q;
    result_d = result_q;
    err_d    = err_q;
    ovf_d    = ovf_q;
    buf_we   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (flush_i) begin
          count_d = '0;
          ovf_d   = 1'b0;
          err_d   = 1'b0;
        end else begin
          if (wr_en_i) begin
            if (count_q < DEPTH_C) begin
              buf_we  = 1'b1;
              count_d = count_q + 1'b1;
            end else begin
              ovf_d = 1'b1;
            end
          end
          if (go_i) begin
            if (count_q == '0) begin
              err_d = 1'b1;
            end else begin
              state_d = CLEAR;
              n_d     = count_q;
            end
          end
        end
      end
      CLEAR: begin
        state_d = START;
        idx_d   = '0;
      end
      START: begin
        idx_d   = 8'd1;
        tmo_d   = '0;
        state_d = (n_q == 8'd1) ? WAIT : STREAM;
      end
      STREAM: begin
        if (idx_q == n_q - 8'd1) state_d = WAIT;
        else                     idx_d   = idx_q + 8'd1;
      end
      WAIT: begin
        if (done_i) begin
          result_d = sum_i;
          state_d  = REPORT;
        end else if (tmo_q == TMO_LAST) begin
          // Give up: result_o keeps the previous capture and no valid pulse is issued.
          err_d   = 1'b1;
          state_d = IDLE;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      REPORT:  state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Registered from next state so the clear is low exactly during CLEAR and held low in reset.
    acc_rst_n_d = (state_d != CLEAR);
  end

  // NOTE: state registers use non-blocking assignments so all flops update together on the edge.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      count_q     <= '0;
      n_q         <= '0;
      idx_q       <= '0;
      tmo_q       <= '0;
      result_q    <= '0;
      err_q       <= 1'b0;
      ovf_q       <= 1'b0;
      acc_rst_n_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      n_q         <= n_d;
      idx_q       <= idx_d;
      tmo_q       <= tmo_d;
      result_q    <= result_d;
      err_q       <= err_d;
      ovf_q       <= ovf_d;
      acc_rst_n_q <= acc_rst_n_d;
    end
  end

  assign busy_o     = (state_q != IDLE);
  assign count_o    = count_q[4:0];
  assign acc_rst_no = acc_rst_n_q;
  assign start_o    = (state_q == START);
  assign n_o        = n_q;
  assign data_o     = (state_q == START || state_q == STREAM) ? buf_rdata : '0;
  assign result_o   = result_q;
  assign valid_o    = (state_q == REPORT);
  assign err_o      = err_q;
  assign ovf_o      = ovf_q;

endmodule

// File: tb/tb_sum_feeder.sv
// Randomized scoreboard bench for sum_feeder with a behavioural accumulator and buffer model.
module tb_sum_feeder;

  localparam int DEPTH   = 16;
  localparam int TIMEOUT = 255;

  logic        clk = 1'b0;
  logic        rst_i = 1'b1;
  logic        wr_en_i = 1'b0;
  logic [7:0]  wr_data_i = '0;
  logic        flush_i = 1'b0;
  logic        go_i = 1'b0;
  logic        busy_o;
  logic [4:0]  count_o;
  logic        acc_rst_no;
  logic        start_o;
  logic [7:0]  n_o;
  logic [7:0]  data_o;
  logic        done_i = 1'b0;
  logic [15:0] sum_i = '0;
  logic [15:0] result_o;
  logic        valid_o;
  logic        err_o;
  logic        ovf_o;

  sum_feeder #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clk_i      (clk),
    .rst_i      (rst_i),
    .wr_en_i    (wr_en_i),
    .wr_data_i  (wr_data_i),
    .flush_i    (flush_i),
    .go_i       (go_i),
    .busy_o     (busy_o),
    .count_o    (count_o),
    .acc_rst_no (acc_rst_no),
    .start_o    (start_o),
    .n_o        (n_o),
    .data_o     (data_o),
    .done_i     (done_i),
    .sum_i      (sum_i),
    .result_o   (result_o),
    .valid_o    (valid_o),
    .err_o      (err_o),
    .ovf_o      (ovf_o)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_mis = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: what the buffer should hold, and the sticky flags.
  logic [7:0] model_buf [DEPTH];
  int         model_count = 0;
  bit         model_ovf   = 0;
  bit         model_err   = 0;

  // Scoreboard queues.
  int          exp_n    [$];
  logic [7:0]  exp_data [$];
  logic [15:0] exp_res  [$];

  // Monitor: compares whatever the DUT presents against the queues.
  int stream_left   = 0;
  bit prev_acc_low  = 0;
  int start_cnt     = 0;
  int acc_low_cnt   = 0;

  always @(negedge clk) begin
    if (rst_i) begin
      stream_left  = 0;
      prev_acc_low = 0;
    end else begin
      if (start_o) begin
        start_cnt++;
        check("acc_clear_before_start", 32'(prev_acc_low), 32'd1);
        if (exp_n.size() == 0) begin
          check("unexpected_start", 32'd1, 32'd0);
          stream_left = int'(n_o);
        end else begin
          int en;
          en = exp_n.pop_front();
          check("n_o_at_start", 32'(n_o), 32'(en));
          stream_left = en;
        end
      end
      if (stream_left > 0) begin
        if (exp_data.size() == 0) check("extra_sample", 32'(data_o), 32'd0);
        else                      check("data_o_stream", 32'(data_o), 32'(exp_data.pop_front()));
        stream_left--;
      end else if (busy_o) begin
        check("data_o_idle_zero", 32'(data_o), 32'd0);
      end
      if (valid_o) begin
        if (exp_res.size() == 0) check("unexpected_valid", 32'd1, 32'd0);
        else                     check("result_o", 32'(result_o), 32'(exp_res.pop_front()));
      end
      if (!acc_rst_no) acc_low_cnt++;
      prev_acc_low = !acc_rst_no;
    end
  end

  // Accumulator model: sums what it is fed, raises done after a random delay.
  bit acc_en      = 1;
  int acc_left    = 0;
  bit acc_pending = 0;
  int acc_delay   = 0;
  logic [15:0] acc_sum = '0;

  always @(negedge clk) begin
    if (rst_i) begin
      acc_sum = '0; acc_left = 0; acc_pending = 0; done_i = 1'b0;
    end else begin
      if (!acc_rst_no) begin
        acc_sum = '0; acc_left = 0; acc_pending = 0; done_i = 1'b0;
      end
      if (start_o) begin
        acc_sum  = 16'(data_o);
        acc_left = int'(n_o) - 1;
        if (acc_left == 0) begin acc_pending = 1; acc_delay = $urandom_range(0, 3); end
      end else if (acc_left > 0) begin
        acc_sum = acc_sum + 16'(data_o);
        acc_left--;
        if (acc_left == 0) begin acc_pending = 1; acc_delay = $urandom_range(0, 3); end
      end
      if (done_i && (valid_o || !busy_o)) begin
        done_i = 1'b0;
      end else if (acc_pending && acc_en) begin
        if (acc_delay == 0) begin done_i = 1'b1; acc_pending = 0; end
        else acc_delay--;
      end
      sum_i = acc_sum;
    end
  end

  task automatic write_sample(input logic [7:0] v);
    @(posedge clk); #1;
    wr_en_i = 1'b1; wr_data_i = v;
    @(posedge clk); #1;
    wr_en_i = 1'b0;
    if (model_count < DEPTH) begin
      model_buf[model_count] = v;
      model_count++;
    end else begin
      model_ovf = 1;
    end
  endtask

  task automatic do_flush(input bit with_write);
    @(posedge clk); #1;
    flush_i = 1'b1; wr_en_i = with_write; wr_data_i = 8'hAA;
    @(posedge clk); #1;
    flush_i = 1'b0; wr_en_i = 1'b0;
    model_count = 0; model_ovf = 0; model_err = 0;
  endtask

  task automatic run(input bit poke, input bit expect_ok);
    int n;
    int busy_cyc;
    int guard;
    logic [15:0] s;
    n = model_count;
    s = '0;
    exp_n.push_back(n);
    for (int i = 0; i < n; i++) begin
      exp_data.push_back(model_buf[i]);
      s = s + 16'(model_buf[i]);
    end
    if (expect_ok) exp_res.push_back(s);
    @(posedge clk); #1; go_i = 1'b1;
    @(posedge clk); #1; go_i = 1'b0;
    @(negedge clk);
    check("clear_cycle_acc_rst", 32'(acc_rst_no), 32'd0);
    check("clear_cycle_busy", 32'(busy_o), 32'd1);
    @(negedge clk);
    check("start_latency", 32'(start_o), 32'd1);
    busy_cyc = 2;
    guard = 0;
    while (busy_o && guard < 3000) begin
      if (poke && !valid_o) begin
        wr_en_i = 1'b1; wr_data_i = 8'($urandom_range(0, 255)); go_i = 1'b1;
      end else begin
        wr_en_i = 1'b0; go_i = 1'b0;
      end
      @(negedge clk);
      guard++;
      if (busy_o) busy_cyc++;
    end
    wr_en_i = 1'b0; go_i = 1'b0;
    check("run_finished_in_bound", 32'(guard < 3000), 32'd1);
    check("stream_complete", 32'(exp_data.size()), 32'd0);
    check("n_o_held", 32'(n_o), 32'(n));
    if (!expect_ok) begin
      model_err = 1;
      check("timeout_busy_cycles", 32'(busy_cyc), 32'(1 + n + TIMEOUT));
    end else begin
      check("result_o_after_run", 32'(result_o), 32'(s));
    end
    check("err_o_after_run", 32'(err_o), 32'(model_err));
    check("count_o_preserved", 32'(count_o), 32'(model_count));
    check("ovf_o_after_run", 32'(ovf_o), 32'(model_ovf));
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"},    32'(busy_o),     32'd0);
    check({tag, "_count"},   32'(count_o),    32'd0);
    check({tag, "_acc_rst"}, 32'(acc_rst_no), 32'd0);
    check({tag, "_start"},   32'(start_o),    32'd0);
    check({tag, "_n"},       32'(n_o),        32'd0);
    check({tag, "_data"},    32'(data_o),     32'd0);
    check({tag, "_result"},  32'(result_o),   32'd0);
    check({tag, "_valid"},   32'(valid_o),    32'd0);
    check({tag, "_err"},     32'(err_o),      32'd0);
    check({tag, "_ovf"},     32'(ovf_o),      32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int s0, a0, k;
    // Power-on reset and first edge after release.
    repeat (2) @(negedge clk);
    check_reset_outputs("por");
    rst_i = 1'b0;
    @(posedge clk); #1;
    check("acc_rst_after_reset", 32'(acc_rst_no), 32'd1);

    // Four samples, with writes and go hammered during the run.
    write_sample(8'd3); write_sample(8'd5); write_sample(8'd7); write_sample(8'd9);
    check("count_after_4", 32'(count_o), 32'd4);
    run(1, 1);
    check("result_24", 32'(result_o), 32'd24);
    run(0, 1);

    // Single sample: no STREAM cycles.
    do_flush(1);
    check("flush_beats_write", 32'(count_o), 32'd0);
    write_sample(8'd200);
    run(0, 1);
    check("result_200", 32'(result_o), 32'd200);

    // go on an empty buffer.
    do_flush(0);
    s0 = start_cnt; a0 = acc_low_cnt;
    @(posedge clk); #1; go_i = 1'b1;
    @(posedge clk); #1; go_i = 1'b0;
    repeat (4) @(negedge clk);
    check("empty_go_err", 32'(err_o), 32'd1);
    check("empty_go_busy", 32'(busy_o), 32'd0);
    check("empty_go_no_start", 32'(start_cnt - s0), 32'd0);
    check("empty_go_no_acc_rst", 32'(acc_low_cnt - a0), 32'd0);
    do_flush(0);
    check("flush_clears_err", 32'(err_o), 32'd0);

    // Overfill: 17 writes into 16 entries.
    for (int i = 0; i < 17; i++) write_sample(8'($urandom_range(0, 255)));
    check("overfill_count", 32'(count_o), 32'd16);
    check("overfill_ovf", 32'(ovf_o), 32'd1);
    run(1, 1);

    // Timeout, then replay of the same buffer.
    acc_en = 0;
    run(0, 0);
    acc_en = 1;
    run(0, 1);

    // Reset in the middle of STREAM.
    do_flush(0);
    for (int i = 0; i < 6; i++) write_sample(8'($urandom_range(1, 255)));
    exp_n.push_back(6);
    for (int i = 0; i < 6; i++) exp_data.push_back(model_buf[i]);
    @(posedge clk); #1; go_i = 1'b1;
    @(posedge clk); #1; go_i = 1'b0;
    repeat (3) @(negedge clk);
    #1 rst_i = 1'b1;
    #1;
    check_reset_outputs("mid_stream_rst");
    exp_n.delete(); exp_data.delete(); exp_res.delete();
    model_count = 0; model_ovf = 0; model_err = 0;
    @(negedge clk);
    rst_i = 1'b0;
    @(posedge clk); #1;
    check("acc_rst_after_mid_rst", 32'(acc_rst_no), 32'd1);
    repeat (3) @(negedge clk);
    check("no_busy_after_mid_rst", 32'(busy_o), 32'd0);

    // Randomized runs.
    for (int r = 0; r < 8; r++) begin
      do_flush(0);
      k = $urandom_range(1, 20);
      for (int i = 0; i < k; i++) write_sample(8'($urandom_range(0, 255)));
      check("rand_count", 32'(count_o), 32'(model_count));
      check("rand_ovf", 32'(ovf_o), 32'(model_ovf));
      run(bit'($urandom_range(0, 1)), 1);
    end

    repeat (4) @(negedge clk);
    check("scoreboard_drained", 32'(exp_n.size() + exp_data.size() + exp_res.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
